// File: rtl/mapache64_pkg.sv
// Shared Mapache64 VRAM types, region base addresses and the fill-DMA state encoding.
package mapache64;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    typedef logic [ADDR_W-1:0] vram_address_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam vram_address_t PMB  = 12'h200;
    localparam vram_address_t NTBL = 12'h400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } fill_state_t;

endpackage

// File: rtl/vram_fill_dma.sv
// Vblank-gated VRAM fill engine sharing the VRAM write port with the CPU.
// The CPU always wins the port; the DMA simply holds on CPU write cycles.
module vram_fill_dma
    import mapache64::*;
#(
    parameter int unsigned LEN_W = 11
) (
    input  logic                cpu_clk,
    input  logic                rst,
    input  logic                vblank_i,
    input  vram_address_t       cfg_dest_i,
    input  logic [LEN_W-1:0]    cfg_len_i,
    input  data_t               cfg_data_i,
    input  logic                cfg_incr_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                cpu_wen_i,
    input  vram_address_t       cpu_address_i,
    input  data_t               cpu_wdata_i,
    output logic                vram_wen_o,
    output vram_address_t       vram_address_o,
    output data_t               vram_wdata_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                cpu_stall_o
);

    fill_state_t       state;
    fill_state_t       state_next;
    vram_address_t     dest_q;
    data_t             data_q;
    logic [LEN_W-1:0]  len_q;
    logic              incr_q;
    logic              dma_fire_c;
    logic              start_ok_c;

    assign start_ok_c  = (state == IDLE) && start_i;
    assign cpu_stall_o = 1'b0;

    // State register
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort outranks everything once the transfer is active
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (cfg_len_i != '0) ? WAIT_VB : DONE;
                end
            end
            WAIT_VB: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (vblank_i) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (!vblank_i) begin
                    state_next = WAIT_VB;
                end else if (!cpu_wen_i && (len_q == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status decode and CPU-priority write mux; reset blocks the DMA but not the CPU
    always_comb begin
        busy_o         = 1'b0;
        done_o         = 1'b0;
        dma_fire_c     = 1'b0;
        vram_wen_o     = cpu_wen_i;
        vram_address_o = cpu_address_i;
        vram_wdata_o   = cpu_wdata_i;
        case (state)
            WAIT_VB: begin
                busy_o = 1'b1;
            end
            WRITE: begin
                busy_o     = 1'b1;
                dma_fire_c = vblank_i && !cpu_wen_i && !abort_i && !rst;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
        if (dma_fire_c) begin
            vram_wen_o     = 1'b1;
            vram_address_o = dest_q;
            vram_wdata_o   = data_q;
        end
    end

    // Transfer descriptor: latched on accepted start, advanced per DMA write
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            dest_q <= '0;
            data_q <= '0;
            len_q  <= '0;
            incr_q <= 1'b0;
        end else if (start_ok_c && (cfg_len_i != '0)) begin
            dest_q <= cfg_dest_i;
            data_q <= cfg_data_i;
            len_q  <= cfg_len_i;
            incr_q <= cfg_incr_i;
        end else if (dma_fire_c) begin
            dest_q <= dest_q + ADDR_W'(1);
            data_q <= data_q + DATA_W'(incr_q);
            len_q  <= len_q - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_vram_fill_dma.sv
// Self-checking bench for vram_fill_dma: directed vector table, corner sequences
// and a randomized run against a transfer-level reference model.
module tb_vram_fill_dma;

    localparam int unsigned LEN_W = 11;

    logic                      cpu_clk;
    logic                      rst;
    logic                      vblank_i;
    mapache64::vram_address_t  cfg_dest_i;
    logic [LEN_W-1:0]          cfg_len_i;
    mapache64::data_t          cfg_data_i;
    logic                      cfg_incr_i;
    logic                      start_i;
    logic                      abort_i;
    logic                      cpu_wen_i;
    mapache64::vram_address_t  cpu_address_i;
    mapache64::data_t          cpu_wdata_i;
    logic                      vram_wen_o;
    mapache64::vram_address_t  vram_address_o;
    mapache64::data_t          vram_wdata_o;
    logic                      busy_o;
    logic                      done_o;
    logic                      cpu_stall_o;

    vram_fill_dma #(.LEN_W(LEN_W)) dut (
        .cpu_clk        (cpu_clk),
        .rst            (rst),
        .vblank_i       (vblank_i),
        .cfg_dest_i     (cfg_dest_i),
        .cfg_len_i      (cfg_len_i),
        .cfg_data_i     (cfg_data_i),
        .cfg_incr_i     (cfg_incr_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .cpu_wen_i      (cpu_wen_i),
        .cpu_address_i  (cpu_address_i),
        .cpu_wdata_i    (cpu_wdata_i),
        .vram_wen_o     (vram_wen_o),
        .vram_address_o (vram_address_o),
        .vram_wdata_o   (vram_wdata_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cpu_stall_o    (cpu_stall_o)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: a transfer accepted at cycle m_s may write from m_s+2 on,
    // in any cycle whose own and previous vblank are high and the CPU is not writing.
    bit                        m_active  = 1'b0;
    int                        m_s       = 0;
    int                        m_rem     = 0;
    int                        m_done    = -1;
    int                        m_idle_ok = 0;
    bit                        m_prev_vb = 1'b0;
    bit                        m_incr    = 1'b0;
    mapache64::vram_address_t  m_dest    = '0;
    mapache64::data_t          m_data    = '0;

    typedef struct {
        mapache64::vram_address_t a;
        mapache64::data_t         d;
    } wr_t;
    wr_t wq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic vb, input logic st, input logic ab,
                        input logic cw, input mapache64::vram_address_t ca,
                        input mapache64::data_t cd);
        bit w;
        rst = r; vblank_i = vb; start_i = st; abort_i = ab;
        cpu_wen_i = cw; cpu_address_i = ca; cpu_wdata_i = cd;
        @(negedge cpu_clk);
        w = m_active && (cyc >= m_s + 2) && m_prev_vb && vb && !cw && !ab && !r;
        check("busy",  32'(busy_o),      32'(m_active));
        check("done",  32'(done_o),      32'(cyc == m_done));
        check("stall", 32'(cpu_stall_o), 32'(0));
        check("wen",   32'(vram_wen_o),  32'(cw | w));
        check("addr",  32'(vram_address_o), 32'((w && !cw) ? m_dest : ca));
        check("wdata", 32'(vram_wdata_o),   32'((w && !cw) ? m_data : cd));
        if (vram_wen_o === 1'b1 && !cw) wq.push_back('{vram_address_o, vram_wdata_o});
        if (r) begin
            m_active = 1'b0; m_done = -1; m_idle_ok = cyc + 1;
        end else if (m_active) begin
            if (ab) begin
                m_active = 1'b0; m_idle_ok = cyc + 1;
            end else if (w) begin
                m_dest = m_dest + 12'(1);
                m_data = m_data + 8'(m_incr);
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 1'b0; m_done = cyc + 1; m_idle_ok = cyc + 2;
                end
            end
        end else if (cyc >= m_idle_ok && st) begin
            if (cfg_len_i != '0) begin
                m_active = 1'b1; m_s = cyc; m_rem = int'(cfg_len_i);
                m_dest = cfg_dest_i; m_data = cfg_data_i; m_incr = cfg_incr_i;
            end else begin
                m_done = cyc + 1; m_idle_ok = cyc + 2;
            end
        end
        m_prev_vb = vb;
        @(posedge cpu_clk);
        #1;
        cyc++;
    endtask

    task automatic cfg(input logic [11:0] d, input int len, input logic [7:0] dat, input logic inc);
        cfg_dest_i = d; cfg_len_i = LEN_W'(len); cfg_data_i = dat; cfg_incr_i = inc;
    endtask

    // Quiet cycle: vblank high, no CPU traffic
    task automatic idle_step(input logic st);
        step(1'b0, 1'b1, st, 1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    typedef struct {
        logic        st;
        logic [11:0] dest;
        int          len;
        logic [7:0]  dat;
        logic        inc;
        logic        eb;
        logic        ed;
        logic        ew;
        logic [11:0] ea;
        logic [7:0]  ewd;
    } vec_t;

    vec_t vt[$];

    initial begin
        rst = 1'b1; vblank_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        cpu_wen_i = 1'b0; cpu_address_i = '0; cpu_wdata_i = '0;
        cfg(12'h000, 0, 8'h00, 1'b0);
        repeat (2) @(posedge cpu_clk);
        #1;

        // Incrementing fill, wrap-around fill, zero-length request (vblank steady)
        vt.push_back('{1, 12'h400, 4, 8'h20, 1, 0, 0, 0, 12'h000, 8'h00});
        vt.push_back('{0, 12'h400, 4, 8'h20, 1, 1, 0, 0, 12'h000, 8'h00});
        vt.push_back('{0, 12'h400, 4, 8'h20, 1, 1, 0, 1, 12'h400, 8'h20});
        vt.push_back('{0, 12'h400, 4, 8'h20, 1, 1, 0, 1, 12'h401, 8'h21});
        vt.push_back('{0, 12'h400, 4, 8'h20, 1, 1, 0, 1, 12'h402, 8'h22});
        vt.push_back('{0, 12'h400, 4, 8'h20, 1, 1, 0, 1, 12'h403, 8'h23});
        vt.push_back('{0, 12'h400, 4, 8'h20, 1, 0, 1, 0, 12'h000, 8'h00});
        vt.push_back('{0, 12'h400, 4, 8'h20, 1, 0, 0, 0, 12'h000, 8'h00});
        vt.push_back('{1, 12'hFFE, 3, 8'hFF, 1, 0, 0, 0, 12'h000, 8'h00});
        vt.push_back('{0, 12'hFFE, 3, 8'hFF, 1, 1, 0, 0, 12'h000, 8'h00});
        vt.push_back('{0, 12'hFFE, 3, 8'hFF, 1, 1, 0, 1, 12'hFFE, 8'hFF});
        vt.push_back('{0, 12'hFFE, 3, 8'hFF, 1, 1, 0, 1, 12'hFFF, 8'h00});
        vt.push_back('{0, 12'hFFE, 3, 8'hFF, 1, 1, 0, 1, 12'h000, 8'h01});
        vt.push_back('{0, 12'hFFE, 3, 8'hFF, 1, 0, 1, 0, 12'h000, 8'h00});
        vt.push_back('{1, 12'h123, 0, 8'h55, 0, 0, 0, 0, 12'h000, 8'h00});
        vt.push_back('{0, 12'h123, 0, 8'h55, 0, 0, 1, 0, 12'h000, 8'h00});
        vt.push_back('{0, 12'h123, 0, 8'h55, 0, 0, 0, 0, 12'h000, 8'h00});

        for (int i = 0; i < vt.size(); i++) begin
            cfg(vt[i].dest, vt[i].len, vt[i].dat, vt[i].inc);
            rst = 1'b0; vblank_i = 1'b1; start_i = vt[i].st; abort_i = 1'b0;
            cpu_wen_i = 1'b0; cpu_address_i = '0; cpu_wdata_i = '0;
            @(negedge cpu_clk);
            check("vec_busy", 32'(busy_o),         32'(vt[i].eb));
            check("vec_done", 32'(done_o),         32'(vt[i].ed));
            check("vec_wen",  32'(vram_wen_o),     32'(vt[i].ew));
            check("vec_addr", 32'(vram_address_o), 32'(vt[i].ea));
            check("vec_data", 32'(vram_wdata_o),   32'(vt[i].ewd));
            @(posedge cpu_clk);
            #1;
        end
        // Bring the model in line with the idle DUT before model-checked steps
        m_prev_vb = 1'b1;
        m_idle_ok = cyc;

        // CPU write steals the second DMA cycle
        wq.delete();
        cfg(12'h100, 3, 8'h50, 1'b0);
        idle_step(1'b1);
        idle_step(1'b0);
        idle_step(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h210, 8'hAA);
        repeat (4) idle_step(1'b0);
        check("cpu_prio_count", 32'(wq.size()), 32'(3));
        if (wq.size() == 3) begin
            check("cpu_prio_a1", 32'(wq[1].a), 32'(12'h101));
            check("cpu_prio_a2", 32'(wq[2].a), 32'(12'h102));
            check("cpu_prio_d2", 32'(wq[2].d), 32'(8'h50));
        end

        // Vblank drops after two of five writes, then resumes
        wq.delete();
        cfg(12'h300, 5, 8'h10, 1'b1);
        idle_step(1'b1);
        repeat (3) idle_step(1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        repeat (6) idle_step(1'b0);
        check("vb_resume_count", 32'(wq.size()), 32'(5));
        if (wq.size() == 5) begin
            check("vb_resume_a2", 32'(wq[2].a), 32'(12'h302));
            check("vb_resume_d4", 32'(wq[4].d), 32'(8'h14));
        end

        // Abort mid-transfer
        wq.delete();
        cfg(12'h050, 8, 8'h01, 1'b1);
        idle_step(1'b1);
        repeat (3) idle_step(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 8'h00);
        repeat (4) idle_step(1'b0);
        check("abort_count", 32'(wq.size()), 32'(2));

        // Reset during WRITE, then a fresh transfer
        wq.delete();
        cfg(12'h600, 6, 8'h80, 1'b1);
        idle_step(1'b1);
        repeat (2) idle_step(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h7AB, 8'h3C);
        check("rst_busy", 32'(busy_o), 32'(0));
        repeat (2) idle_step(1'b0);
        check("rst_count", 32'(wq.size()), 32'(1));
        cfg(12'h020, 2, 8'h40, 1'b0);
        idle_step(1'b1);
        repeat (4) idle_step(1'b0);
        check("rst_restart_count", 32'(wq.size()), 32'(3));
        if (wq.size() == 3) check("rst_restart_a", 32'(wq[2].a), 32'(12'h021));

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic st;
            logic ab;
            st = ($urandom_range(0, 5) == 0);
            ab = !st && ($urandom_range(0, 39) == 0);
            cfg(12'($urandom), int'($urandom_range(0, 12)), 8'($urandom), 1'($urandom));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), st, ab,
                 ($urandom_range(0, 4) == 0), 12'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
